// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection and multi-cycle divider sequencing.
//
// Detects load-use hazards against the E1/E2 load destinations and divider
// hazards (MULT/DIV or MFHI/MFLO issued while the divider is occupied), and
// produces the stall/flush controls for F, D and E1. A taken branch in E1
// squashes D and suppresses any stall, since the D instruction is wrong-path.
//
// Optional feature (macro STALL_COUNTER_EN): adds a saturating 32-bit
// StallCount output that counts cycles with StallD asserted.
//
// Ports:
//   Clock, nReset                 clock, synchronous active-low reset
//   MemReadE1/E2, RAddrE1/E2      load present in E1/E2 and its destination
//   RsAddrD, RtAddrD              D-stage source registers
//   UsesRsD, UsesRtD              D-stage instruction really reads Rs/Rt
//   DivStartD                     D-stage MULT/DIV (starts the divider)
//   HiLoReadD                     D-stage MFHI/MFLO
//   BranchTakenE1                 taken branch redirect from E1
//   StallF, StallD, FlushE1       hold PC and D register, bubble into E1
//   FlushD                        squash D instruction
//   DivBusy                       divider occupied (BUSY or DONE)
//   DivDone                       one-cycle pulse, Hi/Lo written this cycle
//   StallCount                    stall cycle counter (STALL_COUNTER_EN only)

module hazard_ctrl #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       MemReadE1,
   input  logic       MemReadE2,
   input  logic [4:0] RAddrE1,
   input  logic [4:0] RAddrE2,
   input  logic [4:0] RsAddrD,
   input  logic [4:0] RtAddrD,
   input  logic       UsesRsD,
   input  logic       UsesRtD,
   input  logic       DivStartD,
   input  logic       HiLoReadD,
   input  logic       BranchTakenE1,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushE1,
   output logic       FlushD,
   output logic       DivBusy,
`ifdef STALL_COUNTER_EN
   output logic [31:0] StallCount,
`endif
   output logic       DivDone
);

   localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 2);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            load_haz_e1, load_haz_e2, load_haz, div_haz, stall;

   // Register 0 is hardwired to zero, so a load targeting it is never a hazard.
   always_comb begin
      load_haz_e1 = MemReadE1 && (RAddrE1 != 5'd0) &&
                    ((UsesRsD && (RAddrE1 == RsAddrD)) || (UsesRtD && (RAddrE1 == RtAddrD)));
      load_haz_e2 = MemReadE2 && (RAddrE2 != 5'd0) &&
                    ((UsesRsD && (RAddrE2 == RsAddrD)) || (UsesRtD && (RAddrE2 == RtAddrD)));
      load_haz    = load_haz_e1 || load_haz_e2;
      div_haz     = (state_q != StIdle) && (HiLoReadD || DivStartD);
      stall       = (load_haz || div_haz) && !BranchTakenE1;
   end

   assign StallF  = stall;
   assign StallD  = stall;
   assign FlushE1 = stall;
   assign FlushD  = BranchTakenE1;
   assign DivBusy = (state_q != StIdle);
   assign DivDone = (state_q == StDone);

   // Next-state logic. The divide keeps running regardless of stalls or
   // branches: it was issued ahead of anything now in D or E1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (DivStartD && !stall && !BranchTakenE1) begin
               state_d = StBusy;
               cnt_d   = CntLoad;
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef STALL_COUNTER_EN
   logic [31:0] stall_count_q;

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         stall_count_q <= '0;
      end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (DIV_CYCLES = 4).
// Expected outputs are generated by a behavioural model when each cycle's
// stimulus is applied, queued, and compared at the following falling edge.

module tb_hazard_ctrl;

   localparam int unsigned DivCycles = 4;

   logic       Clock = 1'b0;
   logic       nReset;
   logic       MemReadE1, MemReadE2;
   logic [4:0] RAddrE1, RAddrE2, RsAddrD, RtAddrD;
   logic       UsesRsD, UsesRtD, DivStartD, HiLoReadD, BranchTakenE1;
   logic       StallF, StallD, FlushE1, FlushD, DivBusy, DivDone;
`ifdef STALL_COUNTER_EN
   logic [31:0] StallCount;
`endif

   hazard_ctrl #(.DIV_CYCLES(DivCycles)) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .MemReadE1    (MemReadE1),
      .MemReadE2    (MemReadE2),
      .RAddrE1      (RAddrE1),
      .RAddrE2      (RAddrE2),
      .RsAddrD      (RsAddrD),
      .RtAddrD      (RtAddrD),
      .UsesRsD      (UsesRsD),
      .UsesRtD      (UsesRtD),
      .DivStartD    (DivStartD),
      .HiLoReadD    (HiLoReadD),
      .BranchTakenE1(BranchTakenE1),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushE1      (FlushE1),
      .FlushD       (FlushD),
      .DivBusy      (DivBusy),
`ifdef STALL_COUNTER_EN
      .StallCount   (StallCount),
`endif
      .DivDone      (DivDone)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic        stall;
      logic        flush_d;
      logic        busy;
      logic        done;
      logic [31:0] scnt;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: m_rem is the number of remaining non-idle cycles of the divide.
   int          m_rem = 0;
   logic [31:0] m_scnt = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic hit(input logic rd, input logic [4:0] ra);
      return rd && (ra != 5'd0) &&
             ((UsesRsD && ra == RsAddrD) || (UsesRtD && ra == RtAddrD));
   endfunction

   function automatic logic model_stall();
      logic lh, dh;
      lh = hit(MemReadE1, RAddrE1) || hit(MemReadE2, RAddrE2);
      dh = (m_rem > 0) && (HiLoReadD || DivStartD);
      return (lh || dh) && !BranchTakenE1;
   endfunction

   task automatic set_idle();
      MemReadE1 = 0; MemReadE2 = 0; RAddrE1 = 0; RAddrE2 = 0;
      RsAddrD = 0; RtAddrD = 0; UsesRsD = 0; UsesRtD = 0;
      DivStartD = 0; HiLoReadD = 0; BranchTakenE1 = 0; nReset = 1;
   endtask

   // Apply current inputs for one cycle: push expectation, compare mid-cycle,
   // then advance the model across the rising edge.
   task automatic cycle();
      exp_t e, g;
      logic st;
      e.stall   = model_stall();
      e.flush_d = BranchTakenE1;
      e.busy    = (m_rem > 0);
      e.done    = (m_rem == 1);
      e.scnt    = m_scnt;
      q.push_back(e);
      @(negedge Clock);
      g = q.pop_front();
      check_eq("stall_f", {31'd0, StallF}, {31'd0, g.stall});
      check_eq("stall_d", {31'd0, StallD}, {31'd0, g.stall});
      check_eq("flush_e1", {31'd0, FlushE1}, {31'd0, g.stall});
      check_eq("flush_d", {31'd0, FlushD}, {31'd0, g.flush_d});
      check_eq("div_busy", {31'd0, DivBusy}, {31'd0, g.busy});
      check_eq("div_done", {31'd0, DivDone}, {31'd0, g.done});
`ifdef STALL_COUNTER_EN
      check_eq("stall_count", StallCount, g.scnt);
`endif
      st = model_stall();
      @(posedge Clock);
      if (!nReset) begin
         m_rem  = 0;
         m_scnt = '0;
      end else begin
         if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
         if (m_rem > 0) m_rem = m_rem - 1;
         else if (DivStartD && !st && !BranchTakenE1) m_rem = DivCycles;
      end
      #1;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      set_idle();
      nReset = 0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      nReset = 1;

      // Reset state.
      idle_cycles(2);

      // Load-use hazard from E1 on Rs, then with destination r0.
      MemReadE1 = 1; RAddrE1 = 5; RsAddrD = 5; UsesRsD = 1;
      cycle();
      RAddrE1 = 0;
      cycle();

      // Load hazard suppressed by a taken branch.
      RAddrE1 = 5; BranchTakenE1 = 1;
      cycle();

      // E2 hazard on Rt, then Rt not actually read.
      set_idle();
      MemReadE2 = 1; RAddrE2 = 7; RtAddrD = 7; UsesRtD = 1;
      cycle();
      UsesRtD = 0;
      cycle();

      // Divide with MFHI held from cycle 2.
      set_idle();
      DivStartD = 1; cycle();
      DivStartD = 0; cycle();
      HiLoReadD = 1;
      for (int i = 0; i < 4; i++) cycle();
      idle_cycles(2);

      // Branch during divide does not abort it.
      DivStartD = 1; cycle();
      DivStartD = 0; BranchTakenE1 = 1; cycle(); cycle();
      idle_cycles(4);

      // Second MULT/DIV while busy stalls, then issues from idle.
      DivStartD = 1;
      for (int i = 0; i < 8; i++) cycle();
      idle_cycles(6);

      // Divide blocked by a concurrent load hazard is not started.
      DivStartD = 1; MemReadE1 = 1; RAddrE1 = 3; RsAddrD = 3; UsesRsD = 1;
      cycle();
      idle_cycles(2);

      // Reset in the middle of a divide.
      DivStartD = 1; cycle();
      DivStartD = 0; cycle();
      nReset = 0; cycle();
      idle_cycles(6);

      // Ten consecutive load stalls.
      MemReadE1 = 1; RAddrE1 = 9; RtAddrD = 9; UsesRtD = 1;
      for (int i = 0; i < 10; i++) cycle();
      idle_cycles(2);

      // Random traffic with small register numbers for frequent matches.
      for (int i = 0; i < 400; i++) begin
         MemReadE1     = ($urandom_range(0, 2) == 0);
         MemReadE2     = ($urandom_range(0, 2) == 0);
         RAddrE1       = 5'($urandom_range(0, 3));
         RAddrE2       = 5'($urandom_range(0, 3));
         RsAddrD       = 5'($urandom_range(0, 3));
         RtAddrD       = 5'($urandom_range(0, 3));
         UsesRsD       = 1'($urandom_range(0, 1));
         UsesRtD       = 1'($urandom_range(0, 1));
         DivStartD     = ($urandom_range(0, 3) == 0);
         HiLoReadD     = ($urandom_range(0, 3) == 0);
         BranchTakenE1 = ($urandom_range(0, 7) == 0);
         nReset        = ($urandom_range(0, 39) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, sets divider latency in cycles; legal range 2..64.
REQ-002 Clock  input  1  pipeline clock; all state changes on the rising edge.
REQ-003 nReset  input  1  reset, synchronous and active-low.
REQ-004 MemReadE1, MemReadE2  input  1 each  load instruction present in E1 / E2.
REQ-005 RAddrE1, RAddrE2  input  5 each  destination register of the E1 / E2 instruction.
REQ-006 RsAddrD, RtAddrD  input  5 each  source registers of the D-stage instruction.
REQ-007 UsesRsD, UsesRtD  input  1 each  D instruction actually reads Rs / Rt.
REQ-008 DivStartD  input  1  D instruction is MULT/DIV, which starts the divider.
REQ-009 HiLoReadD  input  1  D instruction is MFHI/MFLO.
REQ-010 BranchTakenE1  input  1  branch resolved taken in E1 (redirect).
REQ-011 StallF, StallD  output  1 each  hold the PC and the D pipeline register.
REQ-012 FlushE1  output  1  inject a bubble into E1.
REQ-013 FlushD  output  1  squash the D instruction.
REQ-014 DivBusy  output  1  divider occupied (state != IDLE).
REQ-015 DivDone  output  1  one-cycle pulse; Hi/Lo written at the end of this cycle.

Function
REQ-016 LoadHaz SHALL be 1 when, for X in {E1, E2}, MemReadX && RAddrX!=0 && ((UsesRsD && RAddrX==RsAddrD) || (UsesRtD && RAddrX==RtAddrD)).
REQ-017 DivHaz SHALL be 1 when state!=IDLE && (HiLoReadD || DivStartD).
REQ-018 StallF = StallD = FlushE1 SHALL equal (LoadHaz || DivHaz) && !BranchTakenE1, combinationally, with zero-cycle latency.
REQ-019 FlushD SHALL equal BranchTakenE1; when a branch is taken the stall is suppressed, because the D instruction is wrong-path.
REQ-020 FSM states SHALL be IDLE, BUSY and DONE, with a counter Cnt of width ceil(log2(DIV_CYCLES)).
REQ-021 IDLE->BUSY SHALL occur when DivStartD && !StallD && !BranchTakenE1, loading Cnt = DIV_CYCLES-2.
REQ-022 In BUSY, Cnt SHALL decrement each cycle; when Cnt==0 the FSM SHALL go to DONE, for exactly DIV_CYCLES-1 BUSY cycles in total.
REQ-023 DONE SHALL assert DivDone for one cycle and then go to IDLE unconditionally.
REQ-024 A DivStartD or HiLoReadD seen in BUSY or DONE SHALL stall until the cycle after DONE; it is then accepted from IDLE.
REQ-025 BranchTakenE1 during BUSY or DONE SHALL NOT abort the divide, since the divide issued before the branch.
REQ-026 Load stalls and divider stalls SHALL combine by OR; the divider SHALL keep counting while the pipeline is stalled.
REQ-027 DivBusy SHALL be registered-state-derived: 1 in BUSY and in DONE.

Reset
REQ-028 While nReset==0 at a rising edge: state=IDLE, Cnt=0, and StallCount=0 when present.
REQ-029 After reset: DivBusy=0 and DivDone=0; StallF, StallD, FlushE1 and FlushD follow the inputs combinationally (all 0 with idle inputs).
REQ-030 Reset during BUSY SHALL abandon the divide, with no DivDone pulse.

Configuration
REQ-031 With STALL_COUNTER_EN defined, a 32-bit output StallCount SHALL count the cycles with StallD==1 and saturate at 0xFFFFFFFF.
REQ-032 Without STALL_COUNTER_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 MemReadE1=1, RAddrE1=5, RsAddrD=5, UsesRsD=1 -> StallF=StallD=FlushE1=1 in the same cycle; with RAddrE1=0 -> all 0.
REQ-034 Load hazard plus BranchTakenE1=1 -> StallD=0 and FlushD=1.
REQ-035 DIV_CYCLES=4; DivStartD pulse at cycle 0 -> DivBusy=1 for cycles 1-4, DivDone=1 only at cycle 4, IDLE at cycle 5.
REQ-036 HiLoReadD held from cycle 2 during that divide -> StallD=1 for cycles 2-4, and 0 at cycle 5.
REQ-037 nReset=0 at cycle 2 of a divide -> DivBusy=0 from the next cycle and no DivDone; with STALL_COUNTER_EN, StallCount=0.
REQ-038 With STALL_COUNTER_EN, 10 consecutive stall cycles -> StallCount increments from 0 to 10.
